udma_filter_binpack: RTL and testbench

- Stage directly downstream of the filter binarization/counting unit.
- Consumes its 1-sample-per-beat binary stream, where bit 0 of each beat is the result and the other bits are zero.
- Packs consecutive binary results into DATA_WIDTH-bit words and hands them to the uDMA RX channel writer. A 32-bit write then stores 32 thresholded samples.
- Handles frame boundaries (sof/eof), flushes partial words and reports the number of valid bits per word.

---
 rtl/udma_filter_binpack.sv | 114 +++++++++++
 tb/tb_udma_filter_binpack.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/udma_filter_binpack.sv
// Packs a 1-bit-per-beat binary sample stream into DATA_WIDTH-bit words for the uDMA RX writer.
// Frames are delimited by sof/eof; eof flushes a partial word and output_bits_o reports its fill.
module udma_filter_binpack #(
    parameter int DATA_WIDTH = 32,
    parameter int BCNT_W     = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  cfg_enable_i,
    input  logic                  cfg_msb_first_i,
    input  logic                  cmd_start_i,
    input  logic [DATA_WIDTH-1:0] input_data_i,
    input  logic [1:0]            input_datasize_i,
    input  logic                  input_valid_i,
    input  logic                  input_sof_i,
    input  logic                  input_eof_i,
    output logic                  input_ready_o,
    output logic [DATA_WIDTH-1:0] output_data_o,
    output logic [1:0]            output_datasize_o,
    output logic [BCNT_W-1:0]     output_bits_o,
    output logic                  output_valid_o,
    output logic                  output_sof_o,
    output logic                  output_eof_o,
    input  logic                  output_ready_i,
    output logic                  frame_done_o,
    output logic                  drop_o
);
    localparam int CNT_W = BCNT_W - 1;

    logic [DATA_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]      r_bitcnt;
    logic                  r_sof_pend;
    logic [DATA_WIDTH-1:0] r_out;
    logic [BCNT_W-1:0]     r_out_bits;
    logic                  r_out_valid;
    logic                  r_out_sof;
    logic                  r_out_eof;
    logic                  r_drop;

    logic                  accept;
    logic                  handshake;
    logic                  restart;
    logic                  complete;
    logic [CNT_W-1:0]      cnt_eff;
    logic [CNT_W-1:0]      pos;
    logic [DATA_WIDTH-1:0] acc_next;
    logic                  unused_in;

    assign unused_in = ^{input_data_i[DATA_WIDTH-1:1], input_datasize_i};

    assign input_ready_o = cfg_enable_i & ~cmd_start_i & (~r_out_valid | output_ready_i);
    assign accept        = input_valid_i & input_ready_o;
    assign handshake     = r_out_valid & output_ready_i;

    // A sof arriving mid-word restarts packing from position 0 with a clean accumulator.
    always_comb begin
        restart  = input_sof_i && (r_bitcnt != '0);
        cnt_eff  = restart ? '0 : r_bitcnt;
        pos      = cfg_msb_first_i ? (CNT_W'(DATA_WIDTH - 1) - cnt_eff) : cnt_eff;
        acc_next = restart ? '0 : r_acc;
        acc_next[pos] = input_data_i[0];
        complete = (cnt_eff == CNT_W'(DATA_WIDTH - 1)) || input_eof_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_acc       <= '0;
            r_bitcnt    <= '0;
            r_sof_pend  <= 1'b0;
            r_out       <= '0;
            r_out_bits  <= '0;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_drop      <= 1'b0;
        end else if (cmd_start_i) begin
            r_acc       <= '0;
            r_bitcnt    <= '0;
            r_sof_pend  <= 1'b0;
            r_out_valid <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_drop <= accept & restart;
            if (accept && complete) begin
                // Loading here also covers a same-cycle handshake: the new word replaces the old.
                r_out       <= acc_next;
                r_out_bits  <= BCNT_W'(cnt_eff) + BCNT_W'(1);
                r_out_sof   <= r_sof_pend | input_sof_i;
                r_out_eof   <= input_eof_i;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
                r_bitcnt    <= '0;
                r_sof_pend  <= 1'b0;
            end else begin
                if (handshake) r_out_valid <= 1'b0;
                if (accept) begin
                    r_acc    <= acc_next;
                    r_bitcnt <= cnt_eff + CNT_W'(1);
                    if (input_sof_i) r_sof_pend <= 1'b1;
                end
            end
        end
    end

    assign output_data_o     = r_out;
    assign output_datasize_o = 2'b10;
    assign output_bits_o     = r_out_bits;
    assign output_valid_o    = r_out_valid;
    assign output_sof_o      = r_out_sof;
    assign output_eof_o      = r_out_eof;
    assign frame_done_o      = handshake & r_out_eof;
    assign drop_o            = r_drop;

endmodule

// File: tb/tb_udma_filter_binpack.sv
// Directed bench for udma_filter_binpack: packing order, flush, backpressure, restart, start and reset.
module tb_udma_filter_binpack;
    localparam int DW = 32;
    localparam int BW = 6;

    logic          clk = 1'b0;
    logic          reset, enable, msb_first, start;
    logic [DW-1:0] din;
    logic [1:0]    dsize_in;
    logic          in_valid, in_sof, in_eof, in_ready;
    logic [DW-1:0] dout;
    logic [1:0]    dsize_out;
    logic [BW-1:0] bits;
    logic          out_valid, out_sof, out_eof, out_ready, frame_done, drop;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    udma_filter_binpack #(.DATA_WIDTH(DW), .BCNT_W(BW)) dut (
        .clk_i(clk), .reset_i(reset), .cfg_enable_i(enable), .cfg_msb_first_i(msb_first),
        .cmd_start_i(start), .input_data_i(din), .input_datasize_i(dsize_in),
        .input_valid_i(in_valid), .input_sof_i(in_sof), .input_eof_i(in_eof),
        .input_ready_o(in_ready), .output_data_o(dout), .output_datasize_o(dsize_out),
        .output_bits_o(bits), .output_valid_o(out_valid), .output_sof_o(out_sof),
        .output_eof_o(out_eof), .output_ready_i(out_ready), .frame_done_o(frame_done),
        .drop_o(drop)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat presented for exactly one edge; caller guarantees in_ready.
    task automatic send(input logic b, input logic s, input logic e);
        din = {{(DW-1){1'b1}}, b};   // upper bits must be ignored
        in_sof = s; in_eof = e; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; din = '0;
    endtask

    initial begin
        logic [DW-1:0] got_q[$];
        int idx;
        logic pre;

        reset = 1'b1; enable = 1'b1; msb_first = 1'b0; start = 1'b0;
        din = '0; dsize_in = 2'b01; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", dout, 0);
        check("rst_bits", bits, 0);
        check("rst_drop", drop, 0);
        check("rst_dsize", dsize_out, 2'b10);
        reset = 1'b0;
        tick();

        // T1: LSB-first alternating 1,0 -> 0x55555555
        for (int i = 0; i < 32; i++) begin
            if (i == 31) check("t1_pre_valid", out_valid, 0);
            send((i % 2) == 0, i == 0, 1'b0);
        end
        check("t1_valid", out_valid, 1);
        check("t1_data", dout, 32'h5555_5555);
        check("t1_bits", bits, 32);
        check("t1_sof", out_sof, 1);
        check("t1_eof", out_eof, 0);
        tick();
        check("t1_drained", out_valid, 0);

        // T2: MSB-first 1,1,0,1,1 with eof -> 0xD8000000
        msb_first = 1'b1;
        send(1, 1, 0); send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 0, 1);
        check("t2_data", dout, 32'hD800_0000);
        check("t2_bits", bits, 5);
        check("t2_sof", out_sof, 1);
        check("t2_eof", out_eof, 1);
        check("t2_frame_done", frame_done, 1);
        tick();
        check("t2_frame_done_end", frame_done, 0);

        // T3: LSB-first same beats -> 0x1B
        msb_first = 1'b0;
        send(1, 1, 0); send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 0, 1);
        check("t3_data", dout, 32'h0000_001B);
        check("t3_bits", bits, 5);
        tick();

        // T4: backpressure; word A all ones, word B 0,1,0,1.. -> 0xAAAAAAAA
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 200 && idx < 32; c++) begin
            din = DW'(1); in_valid = 1'b1;
            #1 pre = in_ready;
            tick();
            if (pre) idx++;
        end
        check("t4_a_valid", out_valid, 1);
        check("t4_a_data", dout, 32'hFFFF_FFFF);
        for (int c = 0; c < 10; c++) begin
            din = '0; in_valid = 1'b1;
            #1 check("t4_hold_ready", in_ready, 0);
            tick();
            check("t4_hold_data", dout, 32'hFFFF_FFFF);
            check("t4_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 200 && got_q.size() < 2; c++) begin
            din = DW'((idx - 32) % 2); in_valid = (idx < 64);
            #1 pre = in_ready & in_valid;
            if (out_valid) got_q.push_back(dout);
            tick();
            if (pre) idx++;
        end
        in_valid = 1'b0;
        check("t4_words", got_q.size(), 2);
        check("t4_beats", idx, 64);
        if (got_q.size() == 2) begin
            check("t4_word0", got_q[0], 32'hFFFF_FFFF);
            check("t4_word1", got_q[1], 32'hAAAA_AAAA);
        end
        tick();

        // T5: sof at bitcnt=7 drops partial, new word starts at bit 0
        for (int i = 0; i < 7; i++) send(1, 0, 0);
        send(1, 1, 0);
        check("t5_drop", drop, 1);
        check("t5_no_word", out_valid, 0);
        send(0, 0, 0);
        check("t5_drop_end", drop, 0);
        send(1, 0, 1);
        check("t5_data", dout, 32'h0000_0005);
        check("t5_bits", bits, 3);
        check("t5_sof", out_sof, 1);
        tick();

        // T6: cmd_start drops a pending word, then clears a 12-bit partial
        out_ready = 1'b0;
        send(1, 1, 1);
        check("t6_pending", out_valid, 1);
        start = 1'b1; in_valid = 1'b1; din = DW'(1);
        #1 check("t6_start_ready", in_ready, 0);
        tick();
        start = 1'b0; in_valid = 1'b0;
        check("t6_dropped", out_valid, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) send(1, 0, 0);
        start = 1'b1; in_valid = 1'b1; din = DW'(1);
        #1 check("t6_start_ready2", in_ready, 0);
        tick();
        start = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == 31) check("t6_pre_valid", out_valid, 0);
            send(i >= 16, 0, 0);
        end
        check("t6_data", dout, 32'hFFFF_0000);
        check("t6_bits", bits, 32);
        tick();

        // T7: disable retains the partial word
        send(1, 1, 0);
        enable = 1'b0; in_valid = 1'b1; din = '0;
        for (int c = 0; c < 3; c++) begin
            #1 check("t7_blocked", in_ready, 0);
            tick();
        end
        enable = 1'b1;
        send(1, 0, 1);
        check("t7_data", dout, 32'h0000_0003);
        check("t7_bits", bits, 2);
        tick();

        // T8: synchronous reset with a pending word
        out_ready = 1'b0;
        send(1, 1, 0); send(0, 0, 0); send(1, 0, 1);
        check("t8_pending", out_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t8_valid", out_valid, 0);
        check("t8_data", dout, 0);
        check("t8_bits", bits, 0);
        check("t8_sof", out_sof, 0);
        check("t8_eof", out_eof, 0);
        check("t8_drop", drop, 0);
        out_ready = 1'b1;
        send(1, 0, 1);
        check("t8_after_bits", bits, 1);
        check("t8_after_sof", out_sof, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
